seq_lock_n: RTL
===============

Name: seq_lock_n

Overview:
Parametrised successor to the fixed three-switch lock FSM. It accepts a stream of SYM_W-bit symbols, each qualified by a strobe, and compares them against a programmable CODE_LEN-symbol code. It generates a timed unlock window, a failed-attempt counter with lockout, and an entry timeout. It sits between the prescaled or debounced input logic and the board LEDs, in the same clock domain as its strobe source.

Parameters:
SYM_W, 3, width of one symbol (one switch bank)
CODE_LEN, 4, number of symbols in the code (>=2)
MAX_FAIL, 3, wrong entries that trigger lockout (>=1)
UNLOCK_CYC, 5, cycles unlock stays high (>=1)
LOCKOUT_CYC, 10, cycles inputs are ignored after MAX_FAIL failures (>=1)
ENTRY_TMO, 8, idle cycles mid-entry before progress is discarded (>=1)

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
sym_valid  in  1  one-cycle strobe: sym is a new entry
sym  in  SYM_W  entered symbol
code  in  CODE_LEN*SYM_W  expected code; slot k = code[k*SYM_W +: SYM_W]; slot 0 is entered first; sampled live, must be held stable
relock  in  1  pulse that ends the unlock window early
unlock  out  1  high while in UNLOCKED
lockout  out  1  high while in LOCKOUT
err  out  1  one-cycle pulse on each mismatched symbol
progress  out  $clog2(CODE_LEN+1)  number of correct symbols matched so far
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts

Behaviour:
- Reset (rst=0, async): state=LOCKED, progress=0, fail_cnt=0, timer=0. All outputs are 0 and stay 0 until the first clk edge after rst rises.
- All outputs are registered and reflect the state after the edge at which the event is sampled. Latency from event to output is 1 cycle.
- States: LOCKED, UNLOCKED, LOCKOUT. A single down-timer is shared by entry timeout, the unlock window and the lockout period.
- LOCKED, sym_valid with sym == slot[progress]:
  - If progress < CODE_LEN-1: progress += 1 and timer is loaded with ENTRY_TMO.
  - If progress == CODE_LEN-1: go to UNLOCKED, progress=0, fail_cnt=0, timer=UNLOCK_CYC.
- LOCKED, sym_valid with a mismatch:
  - err=1 for 1 cycle, progress=0, fail_cnt += 1.
  - If the new fail_cnt == MAX_FAIL: go to LOCKOUT with timer=LOCKOUT_CYC.
  - A mismatch on the first symbol (progress=0) also counts as a failure.
- LOCKED, progress>0, no sym_valid: timer decrements. On reaching 0, progress=0. This is not a failure and does not pulse err.
- sym_valid on the same cycle the timer would expire: the symbol is processed and the timeout does not fire.
- relock has no effect in LOCKED or LOCKOUT.
- UNLOCKED:
  - unlock=1 and timer decrements each cycle; at 0, go to LOCKED.
  - relock=1: go to LOCKED next edge. relock takes priority over expiry.
  - sym_valid is ignored, with no err and no count.
- LOCKOUT:
  - lockout=1, sym_valid is ignored and timer decrements.
  - At 0: go to LOCKED with fail_cnt=0.
- Timer width is $clog2(max(UNLOCK_CYC, LOCKOUT_CYC, ENTRY_TMO)+1). No wrap is permitted; decrementing stops at 0.
- Reset asserted mid-entry, mid-unlock or mid-lockout returns the block to the reset state immediately. No progress is retained.
- A code change while progress>0 takes effect on the next compare; no other action is taken.

Decomposition:
- Package seq_lock_pkg holds:
  - state enum {LOCKED, UNLOCKED, LOCKOUT}
  - function clog2_max(a,b,c) for sizing the timer
- One sub-module, lock_timer: loadable down-counter with load, value, enable and zero outputs, parametrised width, same clk/rst. seq_lock_n instantiates one.

Test Plan (defaults; code = {3'd7,3'd4,3'd2,3'd1}):
1. Strobe 1,2,4,7 on consecutive cycles -> progress 1,2,3. Cycle after the 7: unlock=1 for exactly 5 cycles, then 0. fail_cnt=0, err never asserted.
2. Strobe 1,2,5 -> err pulse on the 5, progress=0, fail_cnt=1. Then 1,2,4,7 -> unlock=1 and fail_cnt clears to 0.
3. Three wrong symbols (0,0,0) -> fail_cnt 1,2,3, lockout=1 for 10 cycles. The correct code strobed during lockout has no effect. After lockout, fail_cnt=0 and 1,2,4,7 unlocks.
4. Strobe 1,2, then 8 idle cycles -> progress returns to 0 with no err and fail_cnt unchanged. Repeat with the 4 strobed on the 8th idle cycle -> progress=3.
5. Unlock, then relock on the 2nd unlock cycle with sym_valid on the same cycle -> unlock=0 next cycle, no err.
6. Pull rst low asynchronously (between edges) during lockout and during progress=3 -> all outputs are 0 immediately. After release, 1,2,4,7 unlocks normally.

Source files
------------

// File: rtl/seq_lock_pkg.sv
// Shared types and sizing helpers for the parametrised sequence lock.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_e;

  function automatic int clog2_max(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_lock_n_timer.sv
// Loadable down-counter shared by entry timeout, unlock window and lockout.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/seq_lock_n.sv
// Programmable N-symbol combination lock with unlock window,
// failed-attempt lockout and mid-entry timeout.
module seq_lock_n
  import seq_lock_pkg::*;
#(
  parameter int SYM_W       = 3,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int UNLOCK_CYC  = 5,
  parameter int LOCKOUT_CYC = 10,
  parameter int ENTRY_TMO   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sym_valid,
  input  logic [SYM_W-1:0]          sym,
  input  logic [CODE_LEN*SYM_W-1:0] code,
  input  logic                      relock,
  output logic                      unlock,
  output logic                      lockout,
  output logic                      err,
  output logic [$clog2(CODE_LEN+1)-1:0] progress,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int TW = clog2_max(UNLOCK_CYC, LOCKOUT_CYC, ENTRY_TMO);
  localparam int PW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  state_e        state_q;
  logic [PW-1:0] prog_q;
  logic [FW-1:0] fail_q;
  logic          err_q;

  logic [TW-1:0]    tmr_val;
  logic [TW-1:0]    tmr_cnt;
  logic             tmr_ld;
  logic             tmr_en;
  logic             tmr_zero;
  logic [SYM_W-1:0] slot;
  logic [FW-1:0]    fail_inc;
  logic             hit;
  logic             miss;
  logic             last;
  logic             to_lockout;
  logic             done;

  lock_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_ld),
    .val_i   (tmr_val),
    .en_i    (tmr_en),
    .value_o (tmr_cnt),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    slot       = code[int'(prog_q)*SYM_W +: SYM_W];
    hit        = (state_q == LOCKED) && sym_valid && (sym == slot);
    miss       = (state_q == LOCKED) && sym_valid && (sym != slot);
    last       = (int'(prog_q) == CODE_LEN - 1);
    fail_inc   = fail_q + 1'b1;
    to_lockout = miss && (int'(fail_inc) == MAX_FAIL);
    // "Reaching zero" is the decrement from 1; an idle 0 also counts as done.
    done       = (tmr_cnt == TW'(1)) || tmr_zero;
    tmr_ld     = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    unique case (state_q)
      LOCKED: begin
        if (hit) begin
          tmr_ld  = 1'b1;
          tmr_val = last ? TW'(UNLOCK_CYC) : TW'(ENTRY_TMO);
        end else if (to_lockout) begin
          tmr_ld  = 1'b1;
          tmr_val = TW'(LOCKOUT_CYC);
        end else if (!sym_valid && prog_q != '0) begin
          tmr_en = 1'b1;
        end
      end
      UNLOCKED, LOCKOUT: tmr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOCKED;
      prog_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        LOCKED: begin
          if (hit) begin
            if (last) begin
              state_q <= UNLOCKED;
              prog_q  <= '0;
              fail_q  <= '0;
            end else begin
              prog_q <= prog_q + 1'b1;
            end
          end else if (miss) begin
            err_q  <= 1'b1;
            prog_q <= '0;
            fail_q <= fail_inc;
            if (to_lockout) state_q <= LOCKOUT;
          end else if (prog_q != '0 && done) begin
            prog_q <= '0;
          end
        end
        UNLOCKED: begin
          if (relock || done) state_q <= LOCKED;
        end
        LOCKOUT: begin
          if (done) begin
            state_q <= LOCKED;
            fail_q  <= '0;
          end
        end
        default: state_q <= LOCKED;
      endcase
    end
  end

  assign unlock   = (state_q == UNLOCKED);
  assign lockout  = (state_q == LOCKOUT);
  assign err      = err_q;
  assign progress = prog_q;
  assign fail_cnt = fail_q;

endmodule
